// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: encodings, reset vector,
// ALU operations and the pipeline-register layouts.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_LUI, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        use_imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr_reg;
    logic [4:0]  shamt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  wr_reg;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wr_reg;
    logic        reg_wr;
  } memwb_t;

  // A producer only matters when it really writes a register other than $0.
  function automatic logic reg_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Stall and forwarding-select generation for the ID and EX stages.
module hazard_unit
  import mips_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_br_i,
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] ex_wr_reg_i,
  input  logic       ex_reg_wr_i,
  input  logic       ex_mem_rd_i,
  input  logic [4:0] mem_wr_reg_i,
  input  logic       mem_reg_wr_i,
  input  logic       mem_mem_rd_i,
  input  logic [4:0] wb_wr_reg_i,
  input  logic       wb_reg_wr_i,
  output logic       stall_o,
  output logic       fwd_id_a_o,
  output logic       fwd_id_b_o,
  output logic [1:0] fwd_ex_a_o,
  output logic [1:0] fwd_ex_b_o
);
  logic mem_alu, load_use, br_ex, br_mem;

  assign mem_alu  = mem_reg_wr_i && !mem_mem_rd_i;
  assign load_use = reg_hit(ex_mem_rd_i, ex_wr_reg_i, id_rs_i) ||
                    reg_hit(ex_mem_rd_i, ex_wr_reg_i, id_rt_i);
  // A load in EX trips both terms on consecutive cycles, giving two bubbles.
  assign br_ex    = reg_hit(ex_reg_wr_i, ex_wr_reg_i, id_rs_i) ||
                    reg_hit(ex_reg_wr_i, ex_wr_reg_i, id_rt_i);
  assign br_mem   = reg_hit(mem_mem_rd_i, mem_wr_reg_i, id_rs_i) ||
                    reg_hit(mem_mem_rd_i, mem_wr_reg_i, id_rt_i);
  assign stall_o  = load_use || (id_br_i && (br_ex || br_mem));

  assign fwd_id_a_o = reg_hit(mem_alu, mem_wr_reg_i, id_rs_i);
  assign fwd_id_b_o = reg_hit(mem_alu, mem_wr_reg_i, id_rt_i);

  assign fwd_ex_a_o = reg_hit(mem_alu, mem_wr_reg_i, ex_rs_i)     ? 2'b10 :
                      reg_hit(wb_reg_wr_i, wb_wr_reg_i, ex_rs_i)  ? 2'b01 : 2'b00;
  assign fwd_ex_b_o = reg_hit(mem_alu, mem_wr_reg_i, ex_rt_i)     ? 2'b10 :
                      reg_hit(wb_reg_wr_i, wb_wr_reg_i, ex_rt_i)  ? 2'b01 : 2'b00;
endmodule

// File: rtl/mips_dm.sv
// 4 KiB little-endian byte-array data memory with word-aligned access.
module mips_dm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [9:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [7:0] dm_4k [0:4095];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4096; i++) dm_4k[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) dm_4k[{waddr_i, 2'(b)}] <= wdata_i[8*b +: 8];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rdata_o[8*gi +: 8] = dm_4k[{waddr_i, 2'(gi)}];
  end
endmodule

// File: rtl/mips_im.sv
// Instruction ROM, word addressed by PC[16:2]; contents are loaded from outside
// and survive reset.
module mips_im (
  input  logic [14:0] addr_i,
  output logic [31:0] instr_o
);
  logic [31:0] im_128k [0:32767];

  assign instr_o = im_128k[addr_i];
endmodule

// File: rtl/mips_rf.sv
// 32x32 register file, two read ports, one write port, write-before-read.
module mips_rf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic [31:0] rda_o,
  output logic [31:0] rdb_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] rf [0:31];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      rf[wa_i] <= wd_i;
    end
  end

  assign rda_o = (ra_i == 5'd0) ? 32'd0 : (we_i && (wa_i == ra_i)) ? wd_i : rf[ra_i];
  assign rdb_o = (rb_i == 5'd0) ? 32'd0 : (we_i && (wa_i == rb_i)) ? wd_i : rf[rb_i];
endmodule

// File: rtl/mips_cpu.sv
// Five-stage pipelined MIPS core; branches and jumps resolve in ID with one
// delay slot.
module mips_cpu
  import mips_pkg::*;
(
  input logic Clk,
  input logic Rst
);
  logic [31:0] pc_q, pc_d;
  ifid_t  ifid_q;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic [31:0] if_instr, rs_data, rt_data, dm_rdata;
  logic        stall, fwd_id_a, fwd_id_b;
  logic [1:0]  fwd_ex_a, fwd_ex_b;

  mips_im IM (.addr_i(pc_q[16:2]), .instr_o(if_instr));

  // ---- ID ----
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_pc4, id_sext, id_zext, id_a, id_b, id_target;
  logic        id_br, id_taken;

  assign id_op    = ifid_q.instr[31:26];
  assign id_rs    = ifid_q.instr[25:21];
  assign id_rt    = ifid_q.instr[20:16];
  assign id_rd    = ifid_q.instr[15:11];
  assign id_shamt = ifid_q.instr[10:6];
  assign id_funct = ifid_q.instr[5:0];
  assign id_pc4   = ifid_q.pc + 32'd4;
  assign id_sext  = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
  assign id_zext  = {16'd0, ifid_q.instr[15:0]};

  mips_rf RF (
    .clk_i(Clk), .rst_i(Rst),
    .ra_i(id_rs), .rb_i(id_rt), .rda_o(rs_data), .rdb_o(rt_data),
    .we_i(memwb_q.reg_wr), .wa_i(memwb_q.wr_reg), .wd_i(memwb_q.wdata)
  );

  assign id_a = fwd_id_a ? exmem_q.alu_res : rs_data;
  assign id_b = fwd_id_b ? exmem_q.alu_res : rt_data;

  always_comb begin
    idex_d        = '0;
    idex_d.rs     = id_rs;
    idex_d.rt     = id_rt;
    idex_d.shamt  = id_shamt;
    idex_d.rs_val = rs_data;
    idex_d.rt_val = rt_data;
    id_br         = 1'b0;
    id_taken      = 1'b0;
    id_target     = id_pc4 + {id_sext[29:0], 2'b00};
    case (id_op)
      OP_RTYPE: begin
        idex_d.wr_reg = id_rd;
        idex_d.reg_wr = 1'b1;
        case (id_funct)
          FN_ADDU: idex_d.alu_op = ALU_ADD;
          FN_SUBU: idex_d.alu_op = ALU_SUB;
          FN_AND:  idex_d.alu_op = ALU_AND;
          FN_OR:   idex_d.alu_op = ALU_OR;
          FN_SLT:  idex_d.alu_op = ALU_SLT;
          FN_SLL:  idex_d.alu_op = ALU_SLL;
          FN_JR: begin
            idex_d.reg_wr = 1'b0;
            id_br         = 1'b1;
            id_taken      = 1'b1;
            id_target     = id_a;
          end
          default: idex_d.reg_wr = 1'b0;
        endcase
      end
      OP_ADDIU, OP_ORI, OP_LUI, OP_LW: begin
        idex_d.use_imm = 1'b1;
        idex_d.reg_wr  = 1'b1;
        idex_d.wr_reg  = id_rt;
        idex_d.imm     = (id_op == OP_ADDIU || id_op == OP_LW) ? id_sext : id_zext;
        idex_d.mem_rd  = (id_op == OP_LW);
        idex_d.alu_op  = (id_op == OP_ORI) ? ALU_OR : (id_op == OP_LUI) ? ALU_LUI : ALU_ADD;
      end
      OP_SW: begin
        idex_d.use_imm = 1'b1;
        idex_d.imm     = id_sext;
        idex_d.mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        id_br    = 1'b1;
        id_taken = (id_a == id_b);
      end
      OP_BNE: begin
        id_br    = 1'b1;
        id_taken = (id_a != id_b);
      end
      OP_J, OP_JAL: begin
        id_taken  = 1'b1;
        id_target = {id_pc4[31:28], ifid_q.instr[25:0], 2'b00};
        if (id_op == OP_JAL) begin
          idex_d.alu_op  = ALU_PASSB;
          idex_d.use_imm = 1'b1;
          idex_d.imm     = id_pc4 + 32'd4;
          idex_d.reg_wr  = 1'b1;
          idex_d.wr_reg  = 5'd31;
        end
      end
      default: ;
    endcase
  end

  hazard_unit u_hazard (
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_br_i(id_br),
    .ex_rs_i(idex_q.rs), .ex_rt_i(idex_q.rt), .ex_wr_reg_i(idex_q.wr_reg),
    .ex_reg_wr_i(idex_q.reg_wr), .ex_mem_rd_i(idex_q.mem_rd),
    .mem_wr_reg_i(exmem_q.wr_reg), .mem_reg_wr_i(exmem_q.reg_wr),
    .mem_mem_rd_i(exmem_q.mem_rd),
    .wb_wr_reg_i(memwb_q.wr_reg), .wb_reg_wr_i(memwb_q.reg_wr),
    .stall_o(stall), .fwd_id_a_o(fwd_id_a), .fwd_id_b_o(fwd_id_b),
    .fwd_ex_a_o(fwd_ex_a), .fwd_ex_b_o(fwd_ex_b)
  );

  // ---- EX ----
  logic [31:0] ex_a, ex_b_reg, ex_b, ex_res;

  assign ex_a     = (fwd_ex_a == 2'b10) ? exmem_q.alu_res :
                    (fwd_ex_a == 2'b01) ? memwb_q.wdata : idex_q.rs_val;
  assign ex_b_reg = (fwd_ex_b == 2'b10) ? exmem_q.alu_res :
                    (fwd_ex_b == 2'b01) ? memwb_q.wdata : idex_q.rt_val;
  assign ex_b     = idex_q.use_imm ? idex_q.imm : ex_b_reg;

  always_comb begin
    case (idex_q.alu_op)
      ALU_SUB:   ex_res = ex_a - ex_b;
      ALU_AND:   ex_res = ex_a & ex_b;
      ALU_OR:    ex_res = ex_a | ex_b;
      ALU_SLT:   ex_res = {31'd0, $signed(ex_a) < $signed(ex_b)};
      ALU_SLL:   ex_res = ex_b << idex_q.shamt;
      ALU_LUI:   ex_res = {ex_b[15:0], 16'd0};
      ALU_PASSB: ex_res = ex_b;
      default:   ex_res = ex_a + ex_b;
    endcase
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.alu_res    = ex_res;
    exmem_d.store_data = ex_b_reg;
    exmem_d.wr_reg     = idex_q.wr_reg;
    exmem_d.reg_wr     = idex_q.reg_wr;
    exmem_d.mem_rd     = idex_q.mem_rd;
    exmem_d.mem_wr     = idex_q.mem_wr;
  end

  // ---- MEM ----
  mips_dm DM (
    .clk_i(Clk), .rst_i(Rst), .we_i(exmem_q.mem_wr),
    .waddr_i(exmem_q.alu_res[11:2]), .wdata_i(exmem_q.store_data), .rdata_o(dm_rdata)
  );

  always_comb begin
    memwb_d        = '0;
    memwb_d.wdata  = exmem_q.mem_rd ? dm_rdata : exmem_q.alu_res;
    memwb_d.wr_reg = exmem_q.wr_reg;
    memwb_d.reg_wr = exmem_q.reg_wr;
  end

  assign pc_d = id_taken ? id_target : pc_q + 32'd4;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      if (stall) begin
        idex_q <= '0;
      end else begin
        pc_q         <= pc_d;
        ifid_q.pc    <= pc_q;
        ifid_q.instr <= if_instr;
        idex_q       <= idex_d;
      end
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed program test for mips_cpu: loads a hand-assembled program into IM
// and checks architectural state against hand-computed results.
module tb_mips_cpu;
  import mips_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  mips_cpu dut (.Clk(Clk), .Rst(Rst));

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    dut.IM.im_128k[addr[16:2]] = word;
  endtask

  function automatic logic [31:0] reg_of(input int r);
    return dut.RF.rf[r];
  endfunction

  function automatic logic [31:0] dm_word(input int a);
    return {dut.DM.dm_4k[a+3], dut.DM.dm_4k[a+2], dut.DM.dm_4k[a+1], dut.DM.dm_4k[a]};
  endfunction

  function automatic logic [31:0] nonzero_state();
    int cnt = 0;
    for (int i = 0; i < 32; i++) if (dut.RF.rf[i] != 32'd0) cnt++;
    for (int i = 0; i < 4096; i++) if (dut.DM.dm_4k[i] != 8'd0) cnt++;
    return 32'(cnt);
  endfunction

  initial begin
    for (int i = 0; i < 32768; i++) dut.IM.im_128k[i] = 32'd0;
    put(32'h3000, enc_i(OP_ORI, 0, 1, 16'h1234));
    put(32'h3004, enc_i(OP_LUI, 0, 2, 16'hffff));
    put(32'h3008, enc_r(1, 2, 3, 0, FN_ADDU));
    put(32'h300c, enc_r(1, 1, 4, 0, FN_SUBU));
    put(32'h3010, enc_i(OP_ORI, 0, 5, 16'd8));
    put(32'h3014, enc_i(OP_SW, 5, 3, 16'd4));
    put(32'h3018, enc_i(OP_LW, 5, 6, 16'd4));
    put(32'h301c, enc_r(6, 6, 7, 0, FN_ADDU));
    put(32'h3020, enc_i(OP_BEQ, 1, 1, 16'd2));
    put(32'h3024, enc_i(OP_ORI, 0, 8, 16'd1));
    put(32'h3028, enc_i(OP_ORI, 0, 9, 16'd1));
    put(32'h302c, enc_j(OP_JAL, 26'h0000c40));
    put(32'h3030, enc_i(OP_ADDIU, 11, 11, 16'd1));
    put(32'h3034, enc_i(OP_ORI, 0, 13, 16'h0055));
    put(32'h3038, enc_i(OP_ADDIU, 0, 0, 16'd5));
    put(32'h303c, enc_r(2, 1, 10, 0, FN_SLT));
    put(32'h3040, enc_i(OP_LW, 5, 16, 16'd4));
    put(32'h3044, enc_i(OP_BNE, 16, 3, 16'd2));
    put(32'h3048, enc_r(0, 1, 17, 5'd4, FN_SLL));
    put(32'h304c, enc_i(OP_ORI, 0, 18, 16'd3));
    put(32'h3050, enc_i(OP_ORI, 0, 19, 16'd1));
    put(32'h3054, enc_i(OP_BNE, 19, 0, 16'd2));
    put(32'h3058, enc_r(3, 1, 20, 0, FN_AND));
    put(32'h305c, enc_i(OP_ORI, 0, 21, 16'd5));
    put(32'h3060, enc_j(OP_J, 26'h0000c18));
    put(32'h3064, enc_r(2, 1, 22, 0, FN_OR));
    put(32'h3100, enc_r(31, 0, 0, 0, FN_JR));
    put(32'h3104, enc_i(OP_ADDIU, 14, 14, 16'd1));
    put(32'h3108, enc_i(OP_ORI, 0, 15, 16'd1));

    @(posedge Clk);
    #1;
    Rst = 1'b0;
    check("reset_state_zero", nonzero_state(), 32'd0);
    check("reset_pc", dut.pc_q, 32'h0000_3000);
    check("first_fetch_idx", {17'd0, dut.IM.addr_i}, 32'h0000_0c00);

    repeat (80) @(posedge Clk);
    @(negedge Clk);
    check("ori_r1", reg_of(1), 32'h0000_1234);
    check("lui_r2", reg_of(2), 32'hffff_0000);
    check("addu_fwd_r3", reg_of(3), 32'hffff_1234);
    check("subu_r4", reg_of(4), 32'h0000_0000);
    check("sw_word", dm_word(12), 32'hffff_1234);
    check("sw_byte12", {24'd0, dut.DM.dm_4k[12]}, 32'h0000_0034);
    check("lw_r6", reg_of(6), 32'hffff_1234);
    check("load_use_r7", reg_of(7), 32'hfffe_2468);
    check("beq_slot_r8", reg_of(8), 32'h0000_0001);
    check("beq_skip_r9", reg_of(9), 32'h0000_0000);
    check("jal_link_r31", reg_of(31), 32'h0000_3034);
    check("jal_slot_once_r11", reg_of(11), 32'h0000_0001);
    check("return_r13", reg_of(13), 32'h0000_0055);
    check("jr_slot_r14", reg_of(14), 32'h0000_0001);
    check("jr_skip_r15", reg_of(15), 32'h0000_0000);
    check("write_r0", reg_of(0), 32'h0000_0000);
    check("slt_signed_r10", reg_of(10), 32'h0000_0001);
    check("lw_r16", reg_of(16), 32'hffff_1234);
    check("sll_slot_r17", reg_of(17), 32'h0001_2340);
    check("bne_load_not_taken_r18", reg_of(18), 32'h0000_0003);
    check("and_slot_r20", reg_of(20), 32'h0000_1234);
    check("bne_alu_taken_r21", reg_of(21), 32'h0000_0000);
    check("or_r22", reg_of(22), 32'hffff_1234);

    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    check("midreset_state_zero", nonzero_state(), 32'd0);
    check("midreset_pc", dut.pc_q, 32'h0000_3000);
    check("midreset_im_kept", dut.IM.im_128k[15'hc00], 32'h3401_1234);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
